ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
- Parametrised multi-cycle execute stage for the MIPS pipeline.
- Combines the ALU operand mux, JAL link/rw override and an iterative multiply/divide unit with HI/LO registers.
- Drives a registered EX/MEM output and stalls upstream stages while a mul/div is in progress.

Parameters:
DATA_W, 32, datapath width (even, >=8)
REG_AW, 5, register-number width; JAL destination is all ones
PC_WORD, 1, 1: pc4 is a word index, so link = pc4<<2; 0: link = pc4

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  ID/EX holds a valid instruction
alu_ctrl  in  5  operation code
alu_src  in  1  1: operand B = imm; 0: operand B = b
a  in  DATA_W  operand A
b  in  DATA_W  register operand B
imm  in  DATA_W  extended immediate
rw_in  in  REG_AW  destination register
pc4  in  DATA_W  PC+4
is_jal  in  1  link instruction
reg_we_in  in  1  GPR write enable from decode
flush  in  1  kill the current instruction
stall_o  out  1  hold ID/EX and earlier stages
out_valid  out  1  EX/MEM valid
alu_out  out  DATA_W  EX/MEM result
rw_out  out  REG_AW  EX/MEM destination
reg_we_out  out  1  EX/MEM GPR write enable
ovf_o  out  1  overflow trap flag (optional feature only)

Behaviour:
- Reset values: all outputs 0, HI=LO=0, FSM in IDLE. Reset mid-operation aborts the op.
- Operand B = alu_src ? imm : b.
- alu_ctrl codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift B by A[log2(DATA_W)-1:0].
  - 11 LUI: B << DATA_W/2.
  - 16 MULT, 17 MULTU, 18 DIV, 19 DIVU.
  - 20 MFHI, 21 MFLO, 22 MTHI (HI<=A), 23 MTLO (LO<=A).
  - Any other code yields a result of 0.
- Add/sub wrap modulo 2^DATA_W.
- Single-cycle ops: when in_valid & !stall_o & !flush, the output register updates at the next edge.
  - out_valid=1, alu_out = is_jal ? link : result.
  - rw_out = rw_in | {REG_AW{is_jal}}, reg_we_out = reg_we_in.
  - MTHI/MTLO update HI/LO at the same edge.
- In any cycle without an accepted instruction, the next edge loads a bubble: out_valid=0, reg_we_out=0, other outputs hold.
- FSM states IDLE, BUSY, DONE:
  - IDLE -> BUSY: on in_valid & mul/div code & !flush. stall_o=1 combinationally in this cycle; operands are latched, cnt=DATA_W.
  - BUSY: stall_o=1; one radix-2 shift-add or restoring-divide step per cycle; cnt decrements. At cnt==1, HI/LO are written and the state moves to DONE.
  - DONE: stall_o=0. The held instruction retires as out_valid=1 with reg_we_out=0. Next state is IDLE, and the instruction is not restarted.
  - Total: stall_o is high for DATA_W+1 cycles.
- Mul/div results:
  - MULT/MULTU: {HI,LO} = full 2*DATA_W-bit product.
  - DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed MIN/-1: LO = MIN, HI = 0.
- Stall interaction: an MFHI/MFLO/MTHI/MTLO presented while the FSM is not IDLE is held by stall_o, as is any instruction.
- flush (synchronous) has priority over everything except rst: FSM -> IDLE, HI/LO unchanged, a bubble is loaded, stall_o=0 in that cycle.

Optional Feature:
- Macro EX_OVF_TRAP_EN.
- Defined: signed ADD/SUB overflow on an accepted instruction sets ovf_o=1 for one cycle, aligned with out_valid, and forces reg_we_out=0.
- Undefined: ovf_o is tied to 0 and overflow wraps silently.

Test Plan:
- ADD a=5, imm=7, alu_src=1, rw_in=3, reg_we_in=1 -> next cycle out_valid=1, alu_out=12, rw_out=3, reg_we_out=1.
- JAL, PC_WORD=1, pc4=0x00000401 -> alu_out=0x00001004, rw_out=31.
- MULT a=0xFFFFFFFE (-2), b=3 -> stall_o high 33 cycles; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=9, b=0 -> LO=0xFFFFFFFF, HI=9.
- flush asserted 5 cycles into a DIVU -> stall_o=0 next cycle, HI/LO keep prior values, out_valid=0.
- EX_OVF_TRAP_EN, ADD a=0x7FFFFFFF, b=1 -> ovf_o=1, reg_we_out=0. Without the macro -> alu_out=0x80000000, reg_we_out=1.

Source files
------------

// File: rtl/ex_stage_mc.sv
// Multi-cycle MIPS execute stage: ALU, JAL link override, iterative mul/div with HI/LO.
// Optional signed-overflow trap is enabled by defining EX_OVF_TRAP_EN.
module ex_stage_mc #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned PC_WORD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4:0]        alu_ctrl,
  input  logic              alu_src,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_AW-1:0] rw_in,
  input  logic [DATA_W-1:0] pc4,
  input  logic              is_jal,
  input  logic              reg_we_in,
  input  logic              flush,
  output logic              stall_o,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_AW-1:0] rw_out,
  output logic              reg_we_out,
  output logic              ovf_o
);

  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd10;
  localparam logic [4:0] OP_LUI  = 5'd11;
  localparam logic [4:0] OP_MULT = 5'd16;
  localparam logic [4:0] OP_MULTU= 5'd17;
  localparam logic [4:0] OP_DIV  = 5'd18;
  localparam logic [4:0] OP_DIVU = 5'd19;
  localparam logic [4:0] OP_MFHI = 5'd20;
  localparam logic [4:0] OP_MFLO = 5'd21;
  localparam logic [4:0] OP_MTHI = 5'd22;
  localparam logic [4:0] OP_MTLO = 5'd23;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] md_hi, md_lo, md_b, md_dvd;
  logic              md_div, md_sgn, md_neg_a, md_neg_b, md_dvz;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W-1:0] opb, result, link;
  logic [SH_W-1:0]   sh;
  logic              is_md, start, accept;

  assign opb    = alu_src ? imm : b;
  assign sh     = a[SH_W-1:0];
  assign link   = (PC_WORD != 0) ? (pc4 << 2) : pc4;
  assign is_md  = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_MULTU) ||
                  (alu_ctrl == OP_DIV)  || (alu_ctrl == OP_DIVU);
  assign start  = (state_q == IDLE) && in_valid && is_md && !flush;
  assign accept = (state_q == IDLE) && in_valid && !is_md && !flush;

  // Single-cycle ALU result
  always_comb begin
    result = '0;
    unique case (alu_ctrl)
      OP_ADD:  result = a + opb;
      OP_SUB:  result = a - opb;
      OP_AND:  result = a & opb;
      OP_OR:   result = a | opb;
      OP_XOR:  result = a ^ opb;
      OP_NOR:  result = ~(a | opb);
      OP_SLT:  result = DATA_W'($signed(a) < $signed(opb));
      OP_SLTU: result = DATA_W'(a < opb);
      OP_SLL:  result = opb << sh;
      OP_SRL:  result = opb >> sh;
      OP_SRA:  result = DATA_W'($signed(opb) >>> sh);
      OP_LUI:  result = opb << (DATA_W / 2);
      OP_MFHI: result = hi_q;
      OP_MFLO: result = lo_q;
      default: result = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and stall
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          stall_o = 1'b1;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes for the unsigned iterative core
  logic              sgn_op;
  logic [DATA_W-1:0] mag_a, mag_b;

  assign sgn_op = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
  assign mag_a  = (sgn_op && a[DATA_W-1]) ? (~a + DATA_W'(1)) : a;
  assign mag_b  = (sgn_op && b[DATA_W-1]) ? (~b + DATA_W'(1)) : b;

  // One shift-add or restoring-divide step
  logic [DATA_W:0]   mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
    div_sh   = {md_hi, md_lo[DATA_W-1]};
    div_diff = div_sh - {1'b0, md_b};
    div_ge   = div_sh >= {1'b0, md_b};
    if (md_div) begin
      step_hi = div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
      step_lo = {md_lo[DATA_W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], md_lo[DATA_W-1:1]};
    end
  end

  // Sign fix-up and special cases applied to the final step
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   fin_hi, fin_lo;

  always_comb begin
    prod   = {step_hi, step_lo};
    fin_hi = step_hi;
    fin_lo = step_lo;
    if (!md_div) begin
      if (md_sgn && (md_neg_a ^ md_neg_b)) prod = ~prod + (2*DATA_W)'(1);
      fin_hi = prod[2*DATA_W-1:DATA_W];
      fin_lo = prod[DATA_W-1:0];
    end else if (md_dvz) begin
      fin_hi = md_dvd;
      fin_lo = '1;
    end else begin
      if (md_sgn && (md_neg_a ^ md_neg_b)) fin_lo = ~step_lo + DATA_W'(1);
      if (md_sgn && md_neg_a)              fin_hi = ~step_hi + DATA_W'(1);
    end
  end

  // Iterative mul/div working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_hi    <= '0;
      md_lo    <= '0;
      md_b     <= '0;
      md_dvd   <= '0;
      md_div   <= 1'b0;
      md_sgn   <= 1'b0;
      md_neg_a <= 1'b0;
      md_neg_b <= 1'b0;
      md_dvz   <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      md_hi    <= '0;
      md_lo    <= mag_a;
      md_b     <= mag_b;
      md_dvd   <= a;
      md_div   <= (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU);
      md_sgn   <= sgn_op;
      md_neg_a <= sgn_op && a[DATA_W-1];
      md_neg_b <= sgn_op && b[DATA_W-1];
      md_dvz   <= (b == '0);
      cnt_q    <= CNT_W'(DATA_W);
    end else if (state_q == BUSY && !flush) begin
      md_hi <= step_hi;
      md_lo <= step_lo;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // HI/LO architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept && alu_ctrl == OP_MTHI) begin
      hi_q <= a;
    end else if (accept && alu_ctrl == OP_MTLO) begin
      lo_q <= a;
    end else if (state_q == BUSY && !flush && cnt_q == CNT_W'(1)) begin
      hi_q <= fin_hi;
      lo_q <= fin_lo;
    end
  end

`ifdef EX_OVF_TRAP_EN
  logic ovf;
  always_comb begin
    ovf = 1'b0;
    if (alu_ctrl == OP_ADD)
      ovf = (a[DATA_W-1] == opb[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
    else if (alu_ctrl == OP_SUB)
      ovf = (a[DATA_W-1] != opb[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_o <= 1'b0;
    else     ovf_o <= accept && ovf;
  end
`else
  logic ovf;
  assign ovf   = 1'b0;
  assign ovf_o = 1'b0;
`endif

  // EX/MEM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_out    <= '0;
      rw_out     <= '0;
      reg_we_out <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alu_out    <= is_jal ? link : result;
      rw_out     <= rw_in | {REG_AW{is_jal}};
      reg_we_out <= reg_we_in && !ovf;
    end else if (state_q == DONE && !flush) begin
      out_valid  <= 1'b1;
      reg_we_out <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      reg_we_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed self-checking bench for ex_stage_mc (default 32-bit configuration).
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  alu_ctrl;
  logic        alu_src;
  logic [31:0] a, b, imm, pc4;
  logic [4:0]  rw_in;
  logic        is_jal, reg_we_in, flush;
  logic        stall_o, out_valid, reg_we_out, ovf_o;
  logic [31:0] alu_out;
  logic [4:0]  rw_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(.DATA_W(32), .REG_AW(5), .PC_WORD(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .alu_src(alu_src), .a(a), .b(b), .imm(imm), .rw_in(rw_in), .pc4(pc4),
    .is_jal(is_jal), .reg_we_in(reg_we_in), .flush(flush), .stall_o(stall_o),
    .out_valid(out_valid), .alu_out(alu_out), .rw_out(rw_out),
    .reg_we_out(reg_we_out), .ovf_o(ovf_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one instruction for one cycle; returns #1 after the capturing edge
  task automatic issue(input logic [4:0] ctrl, input logic [31:0] va, input logic [31:0] vb);
    alu_ctrl = ctrl; a = va; b = vb; alu_src = 1'b0; is_jal = 1'b0;
    rw_in = 5'd5; reg_we_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_muldiv(input string tag, input logic [4:0] ctrl,
                            input logic [31:0] va, input logic [31:0] vb);
    int n;
    alu_ctrl = ctrl; a = va; b = vb; alu_src = 1'b0; is_jal = 1'b0;
    rw_in = 5'd0; reg_we_in = 1'b0; in_valid = 1'b1;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stall_cycles"}, 64'(n), 64'd33);
    @(posedge clk); #1;
    check({tag, "_retire_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_retire_we"}, 64'(reg_we_out), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(5'd20, 32'd0, 32'd0);
    check({tag, "_hi"}, 64'(alu_out), 64'(exp_hi));
    issue(5'd21, 32'd0, 32'd0);
    check({tag, "_lo"}, 64'(alu_out), 64'(exp_lo));
  endtask

  localparam int NV = 13;
  logic [4:0]  v_ctrl [NV] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                               5'd8, 5'd9, 5'd10, 5'd10, 5'd11, 5'd31};
  logic [31:0] v_a    [NV] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hFF00, 32'd0, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'd4, 32'd4, 32'd4, 32'd36, 32'd0, 32'd5};
  logic [31:0] v_b    [NV] = '{32'd7, 32'hFF00, 32'h0F0F, 32'h0FF0, 32'd0, 32'd1, 32'd1,
                               32'd1, 32'h80000000, 32'h80000000, 32'h80000000,
                               32'h1234, 32'd5};
  logic [31:0] v_exp  [NV] = '{32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'hF0F0, 32'hFFFFFFFF,
                               32'd1, 32'd0, 32'd16, 32'h08000000, 32'hF8000000,
                               32'hF8000000, 32'h12340000, 32'd0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; alu_src = 1'b0; a = '0; b = '0;
    imm = '0; pc4 = '0; rw_in = '0; is_jal = 1'b0; reg_we_in = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_alu_out", 64'(alu_out), 64'd0);
    check("rst_rw", 64'(rw_out), 64'd0);
    check("rst_we", 64'(reg_we_out), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with immediate
    alu_ctrl = 5'd0; a = 32'd5; imm = 32'd7; alu_src = 1'b1; rw_in = 5'd3;
    reg_we_in = 1'b1; is_jal = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_src = 1'b0;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(alu_out), 64'd12);
    check("add_rw", 64'(rw_out), 64'd3);
    check("add_we", 64'(reg_we_out), 64'd1);
    @(posedge clk); #1;
    check("bubble_valid", 64'(out_valid), 64'd0);
    check("bubble_we", 64'(reg_we_out), 64'd0);
    check("bubble_hold", 64'(alu_out), 64'd12);

    // JAL link override
    alu_ctrl = 5'd0; a = 32'd1; b = 32'd2; pc4 = 32'h00000401; rw_in = 5'd0;
    is_jal = 1'b1; reg_we_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; is_jal = 1'b0;
    check("jal_link", 64'(alu_out), 64'h00001004);
    check("jal_rw", 64'(rw_out), 64'd31);

    for (int i = 0; i < NV; i++) begin
      issue(v_ctrl[i], v_a[i], v_b[i]);
      check($sformatf("alu_op%0d_vec%0d", v_ctrl[i], i), 64'(alu_out), 64'(v_exp[i]));
    end

    run_muldiv("mult", 5'd16, 32'hFFFFFFFE, 32'd3);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_muldiv("multu", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_hilo("multu", 32'hFFFFFFFE, 32'h00000001);
    run_muldiv("div", 5'd18, 32'hFFFFFFF9, 32'd2);
    read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_muldiv("divu_zero", 5'd19, 32'd9, 32'd0);
    read_hilo("divu_zero", 32'd9, 32'hFFFFFFFF);
    run_muldiv("div_min", 5'd18, 32'h80000000, 32'hFFFFFFFF);
    read_hilo("div_min", 32'd0, 32'h80000000);
    run_muldiv("divu", 5'd19, 32'd100, 32'd7);
    read_hilo("divu", 32'd2, 32'd14);

    // Flush an in-flight DIVU
    issue(5'd22, 32'h1234, 32'd0);
    issue(5'd23, 32'h5678, 32'd0);
    alu_ctrl = 5'd19; a = 32'd50; b = 32'd3; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_stall_now", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_stall_next", 64'(stall_o), 64'd0);
    check("flush_bubble", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    read_hilo("flush", 32'h1234, 32'h5678);

    // Overflow behaviour
    issue(5'd0, 32'h7FFFFFFF, 32'd1);
`ifdef EX_OVF_TRAP_EN
    check("ovf_flag", 64'(ovf_o), 64'd1);
    check("ovf_we", 64'(reg_we_out), 64'd0);
`else
    check("ovf_wrap", 64'(alu_out), 64'h80000000);
    check("ovf_we", 64'(reg_we_out), 64'd1);
    check("ovf_flag", 64'(ovf_o), 64'd0);
`endif

    // Reset in the middle of a multiply
    alu_ctrl = 5'd16; a = 32'd3; b = 32'd3; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    read_hilo("midrst", 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
